lsq_gen: RTL and testbench
==========================

# lsq_gen

Parametrised load/store queue for the out-of-order core, sitting between dispatch, the memory FU and the ROB commit port. Entries are allocated in program order at dispatch and filled with address/data when the memory FU executes them. Executing loads get a registered store-to-load forwarding verdict that respects age and byte coverage. Committed stores drain in order to the data cache as byte-masked writes, and a mispredict squashes the younger tail of the queue.

## Interface
- DEPTH, 8: number of entries; power of 2, at least 2
- TAG_W, 5: ROB tag width
- ROB_SIZE, 16: ROB entries; used for age arithmetic modulo ROB_SIZE
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, sampled on posedge clk
- alloc_valid / alloc_rob_tag / alloc_is_store  in  1/TAG_W/1  dispatch allocation
- alloc_ready  out  1  = !full && !flush
- exec_valid / exec_rob_tag  in  1/TAG_W  memory FU result for an allocated entry
- exec_addr / exec_data  in  32/32  effective address; store source data, LSB-aligned
- exec_size / exec_unsigned  in  2/1  00 byte, 01 half, 10 word; zero-extend loads
- ld_resp_valid / ld_resp_rob_tag  out  1/TAG_W  load verdict, registered
- ld_resp_kind  out  2  00 MEMORY, 01 FORWARD, 10 STALL
- ld_resp_data  out  32  forwarded data, sign- or zero-extended; 0 unless FORWARD
- commit_valid / commit_rob_tag  in  1/TAG_W  ROB head retiring
- st_wb_valid / st_wb_addr / st_wb_data / st_wb_mask  out  1/32/32/4  word-aligned cache write
- flush / flush_rob_tag / rob_head  in  1/TAG_W/TAG_W  mispredict; ROB head for age arithmetic
- count / full / empty  out  $clog2(DEPTH)+1 / 1 / 1  occupancy

## Operation
- Entry fields: valid, rob_tag, is_store, done (executed), word addr[31:2], byte mask[3:0], lane-aligned data[31:0], size, unsigned.
- Circular buffer with head (oldest) and tail pointers. Pointers wrap modulo DEPTH.
- Alloc: if alloc_valid && alloc_ready, write the tail entry, set done=0, increment tail.
- Exec: update the valid entry with rob_tag==exec_rob_tag. The tag must match and done must be 0, otherwise the exec is ignored.
  - mask = {0001, 0011, 1111}[size] << addr[1:0].
  - data = exec_data << (8*addr[1:0]).
  - Decode guarantees natural alignment; the queue does not check it.
- Load verdict: on exec of a load, scan stores strictly older than the load's entry, from youngest to oldest.
  - If any older store has done=0: STALL.
  - Else, at the youngest store whose word addr matches and whose mask overlaps the load mask:
    - store mask covers the load mask: FORWARD, with bytes extracted from store lanes and extended per size/unsigned;
    - partial coverage: STALL.
  - No overlapping store: MEMORY.
  - The verdict uses entry state before this cycle's exec update.
- Commit: if commit_valid, head valid, done, and head rob_tag==commit_rob_tag, dequeue the head.
  - If the head is a store, pulse st_wb_* next cycle with {addr,2'b00}, data, mask.
  - Otherwise the commit is ignored.
- Flush: age(t) = (t - rob_head) mod ROB_SIZE. Invalidate every entry with age > age(flush_rob_tag).
  - The squashed entries form a contiguous tail, so tail moves to the oldest squashed slot.
  - count is recomputed.
- Simultaneous events:
  - Flush + alloc: alloc is dropped.
  - Flush + commit: the commit is applied.
  - Flush + exec of a squashed tag: the exec is dropped and no ld_resp is issued.
  - Alloc + commit when full: alloc is refused, because alloc_ready uses pre-commit full.
  - Alloc + commit otherwise: both are applied and count is unchanged.

## Timing
- Reset: all entries invalid, head=tail=0, count=0, empty=1, full=0. Every ld_resp_* and st_wb_* output is 0.
- ld_resp_*: exactly 1 cycle after the load exec; a 1-cycle pulse. A STALL is re-requested by the FU re-sending exec with done still 0.
  - A STALL verdict leaves the load entry's done at 0.
  - MEMORY or FORWARD sets done=1.
- st_wb_valid: 1 cycle after commit, a 1-cycle pulse. Back-to-back commits give back-to-back pulses.
- full, empty, count and alloc_ready reflect registered state; alloc_ready additionally depends combinationally on flush.
- Reset mid-operation discards all entries and pending outputs in the same edge.

## Structure
- types_pkg additions:
  - lsq_entry_t struct;
  - mem_size_t enum (SZ_B, SZ_H, SZ_W);
  - ld_kind_t enum (LD_MEM, LD_FWD, LD_STALL).
- Sub-module lsq_fwd_unit: purely combinational age-ordered priority scan and byte extraction. Its inputs are the entry array, head, the load's slot, addr, size and unsigned; its outputs are the kind and the data.

## Test plan
- Store then load, forwarding: sw 0xDEADBEEF at 0x100, then lw 0x100 → FORWARD, 0xDEADBEEF; lb 0x103 → FORWARD, 0xFFFFFFDE; lbu 0x103 → 0x000000DE.
- Partial coverage: sh 0x1234 at 0x202, then lw 0x200 → STALL.
  - Commit the store → st_wb mask 1100, data 0x12340000.
  - Re-exec the lw → MEMORY.
- Unexecuted older store: alloc st and ld, exec only the ld → STALL.
  - Exec the st at a different word, then re-exec the ld → MEMORY.
- Fill, drain and wrap: fill DEPTH=8 entries → full=1, alloc_ready=0.
  - 20 interleaved alloc/commit cycles wrap the pointers with count stable; no lost or duplicated st_wb.
- Flush: rob_head=14, entries with tags 14, 15, 0, 1, flush_rob_tag=15.
  - Tags 0 and 1 are squashed, count=2, and tail points to the slot after tag 15.
  - An exec of tag 0 in the same cycle produces no ld_resp.
- Reset mid-drain: assert reset on the cycle of a commit → next cycle st_wb_valid=0, count=0, empty=1.

Source files
------------

// File: rtl/lsq_gen_pkg.sv
// Shared types for the load/store queue: entry layout, access sizes,
// load verdict kinds and the byte-lane mask helper.
package lsq_gen_pkg;

   localparam int LSQ_TAG_MAX = 8;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      LD_MEM   = 2'b00,
      LD_FWD   = 2'b01,
      LD_STALL = 2'b10
   } ld_kind_t;

   // rob_tag is held zero-extended to LSQ_TAG_MAX so the struct is fixed-width
   typedef struct packed {
      logic                   valid;
      logic [LSQ_TAG_MAX-1:0] rob_tag;
      logic                   is_store;
      logic                   done;
      logic [29:0]            addr;
      logic [3:0]             mask;
      logic [31:0]            data;
      mem_size_t              size;
      logic                   uns;
   } lsq_entry_t;

   function automatic logic [3:0] lane_mask(input mem_size_t sz, input logic [1:0] off);
      logic [3:0] base;
      case (sz)
         SZ_B:    base = 4'b0001;
         SZ_H:    base = 4'b0011;
         default: base = 4'b1111;
      endcase
      return base << off;
   endfunction

endpackage

// File: rtl/lsq_gen_fwd_unit.sv
// Store-to-load forwarding verdict: scans stores older than the load,
// youngest match wins, and extracts/extends the forwarded bytes.
module lsq_fwd_unit
   import lsq_gen_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  lsq_entry_t                 entries [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]   head,
   input  logic [$clog2(DEPTH)-1:0]   ld_slot,
   input  logic [31:0]                ld_addr,
   input  logic [1:0]                 ld_size,
   input  logic                       ld_unsigned,
   output ld_kind_t                   kind,
   output logic [31:0]                data
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] ld_pos;
   logic [PW-1:0] slot;
   logic [3:0]    ld_mask;
   logic          pend;
   logic          hit;
   lsq_entry_t    sel;
   logic [31:0]   lanes;

   always_comb begin
      ld_mask = lane_mask(mem_size_t'(ld_size), ld_addr[1:0]);
      ld_pos  = ld_slot - head;
      pend    = 1'b0;
      hit     = 1'b0;
      sel     = '0;
      slot    = '0;
      // Oldest to youngest, so the last overlapping store recorded is the youngest
      for (int unsigned k = 0; k < DEPTH; k++) begin
         slot = head + PW'(k);
         if (PW'(k) < ld_pos && entries[slot].valid && entries[slot].is_store) begin
            if (!entries[slot].done) begin
               pend = 1'b1;
            end else if (entries[slot].addr == ld_addr[31:2] &&
                         (entries[slot].mask & ld_mask) != 4'b0000) begin
               hit = 1'b1;
               sel = entries[slot];
            end
         end
      end

      lanes = sel.data >> {ld_addr[1:0], 3'b000};
      kind  = LD_MEM;
      data  = '0;
      if (pend) begin
         kind = LD_STALL;
      end else if (hit) begin
         if ((sel.mask & ld_mask) != ld_mask) begin
            kind = LD_STALL;
         end else begin
            kind = LD_FWD;
            case (mem_size_t'(ld_size))
               SZ_B:    data = ld_unsigned ? {24'h0, lanes[7:0]}  : {{24{lanes[7]}}, lanes[7:0]};
               SZ_H:    data = ld_unsigned ? {16'h0, lanes[15:0]} : {{16{lanes[15]}}, lanes[15:0]};
               default: data = lanes;
            endcase
         end
      end
   end

endmodule

// File: rtl/lsq_gen.sv
// Load/store queue: in-order allocation, out-of-order execution fill,
// registered forwarding verdicts, in-order store drain and tail squash.
module lsq_gen
   import lsq_gen_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int TAG_W    = 5,
   parameter int ROB_SIZE = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alloc_valid,
   input  logic [TAG_W-1:0]         alloc_rob_tag,
   input  logic                     alloc_is_store,
   output logic                     alloc_ready,
   input  logic                     exec_valid,
   input  logic [TAG_W-1:0]         exec_rob_tag,
   input  logic [31:0]              exec_addr,
   input  logic [31:0]              exec_data,
   input  logic [1:0]               exec_size,
   input  logic                     exec_unsigned,
   output logic                     ld_resp_valid,
   output logic [TAG_W-1:0]         ld_resp_rob_tag,
   output logic [1:0]               ld_resp_kind,
   output logic [31:0]              ld_resp_data,
   input  logic                     commit_valid,
   input  logic [TAG_W-1:0]         commit_rob_tag,
   output logic                     st_wb_valid,
   output logic [31:0]              st_wb_addr,
   output logic [31:0]              st_wb_data,
   output logic [3:0]               st_wb_mask,
   input  logic                     flush,
   input  logic [TAG_W-1:0]         flush_rob_tag,
   input  logic [TAG_W-1:0]         rob_head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int          PW = $clog2(DEPTH);
   localparam logic [31:0] RS = 32'(ROB_SIZE);

   lsq_entry_t     ent [DEPTH];
   logic [PW-1:0]  head, tail;

   logic           alloc_fire, commit_fire, exec_hit, exec_fire, ld_fire;
   logic [PW-1:0]  exec_slot, flush_tail, scan_slot;
   logic [PW:0]    flush_cnt;
   logic           flush_any;
   logic [DEPTH-1:0] squash;
   logic [3:0]     exec_mask;
   logic [31:0]    exec_lane;
   lsq_entry_t     new_ent;
   ld_kind_t       fwd_kind;
   logic [31:0]    fwd_data;

   function automatic logic [31:0] age_of(input logic [TAG_W-1:0] t);
      return (32'(t) % RS + RS - 32'(rob_head) % RS) % RS;
   endfunction

   always_comb begin
      full        = (count == (PW+1)'(DEPTH));
      empty       = (count == '0);
      alloc_ready = !full && !flush;
      alloc_fire  = alloc_valid && alloc_ready;
      commit_fire = commit_valid && ent[head].valid && ent[head].done &&
                    ent[head].rob_tag == LSQ_TAG_MAX'(commit_rob_tag);

      exec_hit  = 1'b0;
      exec_slot = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!exec_hit && ent[i].valid && !ent[i].done &&
             ent[i].rob_tag == LSQ_TAG_MAX'(exec_rob_tag)) begin
            exec_hit  = 1'b1;
            exec_slot = PW'(i);
         end
      end

      // A head retiring in the flush cycle is committed, never squashed
      for (int unsigned i = 0; i < DEPTH; i++) begin
         squash[i] = flush && ent[i].valid && !(commit_fire && PW'(i) == head) &&
                     age_of(TAG_W'(ent[i].rob_tag)) > age_of(flush_rob_tag);
      end

      flush_any  = 1'b0;
      flush_tail = tail;
      flush_cnt  = count;
      scan_slot  = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         scan_slot = head + PW'(k);
         if (!flush_any && squash[scan_slot]) begin
            flush_any  = 1'b1;
            flush_tail = scan_slot;
            flush_cnt  = (PW+1)'(k);
         end
      end

      exec_fire = exec_valid && exec_hit && !squash[exec_slot];
      ld_fire   = exec_fire && !ent[exec_slot].is_store;
      exec_mask = lane_mask(mem_size_t'(exec_size), exec_addr[1:0]);
      exec_lane = exec_data << {exec_addr[1:0], 3'b000};

      new_ent          = '0;
      new_ent.valid    = 1'b1;
      new_ent.rob_tag  = LSQ_TAG_MAX'(alloc_rob_tag);
      new_ent.is_store = alloc_is_store;
   end

   lsq_fwd_unit #(.DEPTH(DEPTH)) u_fwd (
      .entries     (ent),
      .head        (head),
      .ld_slot     (exec_slot),
      .ld_addr     (exec_addr),
      .ld_size     (exec_size),
      .ld_unsigned (exec_unsigned),
      .kind        (fwd_kind),
      .data        (fwd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         ld_resp_valid   <= 1'b0;
         ld_resp_rob_tag <= '0;
         ld_resp_kind    <= '0;
         ld_resp_data    <= '0;
         st_wb_valid     <= 1'b0;
         st_wb_addr      <= '0;
         st_wb_data      <= '0;
         st_wb_mask      <= '0;
      end else begin
         ld_resp_valid   <= ld_fire;
         ld_resp_rob_tag <= ld_fire ? exec_rob_tag : '0;
         ld_resp_kind    <= ld_fire ? fwd_kind : LD_MEM;
         ld_resp_data    <= (ld_fire && fwd_kind == LD_FWD) ? fwd_data : '0;

         st_wb_valid <= commit_fire && ent[head].is_store;
         st_wb_addr  <= (commit_fire && ent[head].is_store) ? {ent[head].addr, 2'b00} : '0;
         st_wb_data  <= (commit_fire && ent[head].is_store) ? ent[head].data : '0;
         st_wb_mask  <= (commit_fire && ent[head].is_store) ? ent[head].mask : '0;

         if (commit_fire) ent[head].valid <= 1'b0;

         if (exec_fire) begin
            ent[exec_slot].addr <= exec_addr[31:2];
            ent[exec_slot].mask <= exec_mask;
            ent[exec_slot].data <= exec_lane;
            ent[exec_slot].size <= mem_size_t'(exec_size);
            ent[exec_slot].uns  <= exec_unsigned;
            ent[exec_slot].done <= ent[exec_slot].is_store || fwd_kind != LD_STALL;
         end

         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (squash[i]) ent[i].valid <= 1'b0;
         end

         if (alloc_fire) ent[tail] <= new_ent;

         head <= head + PW'(commit_fire);
         if (flush_any) begin
            tail  <= flush_tail;
            count <= flush_cnt - (PW+1)'(commit_fire);
         end else begin
            tail  <= tail + PW'(alloc_fire);
            count <= count + (PW+1)'(alloc_fire) - (PW+1)'(commit_fire);
         end
      end
   end

endmodule

// File: tb/tb_lsq_gen.sv
// Scoreboard bench for lsq_gen: stimulus pushes expected load verdicts and
// store writebacks; a negedge monitor pops and compares them.
module tb_lsq_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        alloc_valid, alloc_is_store, alloc_ready;
   logic [4:0]  alloc_rob_tag;
   logic        exec_valid, exec_unsigned;
   logic [4:0]  exec_rob_tag;
   logic [31:0] exec_addr, exec_data;
   logic [1:0]  exec_size;
   logic        ld_resp_valid;
   logic [4:0]  ld_resp_rob_tag;
   logic [1:0]  ld_resp_kind;
   logic [31:0] ld_resp_data;
   logic        commit_valid;
   logic [4:0]  commit_rob_tag;
   logic        st_wb_valid;
   logic [31:0] st_wb_addr, st_wb_data;
   logic [3:0]  st_wb_mask;
   logic        flush;
   logic [4:0]  flush_rob_tag, rob_head;
   logic [3:0]  count;
   logic        full, empty;

   typedef struct { logic [4:0] tag; logic [1:0] kind; logic [31:0] data; } ld_exp_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] mask; } st_exp_t;

   ld_exp_t ldq[$];
   st_exp_t stq[$];
   int checks = 0;
   int errors = 0;

   lsq_gen #(.DEPTH(8), .TAG_W(5), .ROB_SIZE(16)) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_rob_tag(alloc_rob_tag),
      .alloc_is_store(alloc_is_store), .alloc_ready(alloc_ready),
      .exec_valid(exec_valid), .exec_rob_tag(exec_rob_tag), .exec_addr(exec_addr),
      .exec_data(exec_data), .exec_size(exec_size), .exec_unsigned(exec_unsigned),
      .ld_resp_valid(ld_resp_valid), .ld_resp_rob_tag(ld_resp_rob_tag),
      .ld_resp_kind(ld_resp_kind), .ld_resp_data(ld_resp_data),
      .commit_valid(commit_valid), .commit_rob_tag(commit_rob_tag),
      .st_wb_valid(st_wb_valid), .st_wb_addr(st_wb_addr), .st_wb_data(st_wb_data),
      .st_wb_mask(st_wb_mask),
      .flush(flush), .flush_rob_tag(flush_rob_tag), .rob_head(rob_head),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ld_resp_valid) begin
         if (ldq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ld_unexpected: got tag %0d kind %0d expected no response",
                     ld_resp_rob_tag, ld_resp_kind);
         end else begin
            ld_exp_t e;
            e = ldq.pop_front();
            chk("ld_tag", 32'(ld_resp_rob_tag), 32'(e.tag));
            chk("ld_kind", 32'(ld_resp_kind), 32'(e.kind));
            chk("ld_data", ld_resp_data, e.data);
         end
      end
      if (st_wb_valid) begin
         if (stq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL st_unexpected: got addr 0x%08h expected no writeback", st_wb_addr);
         end else begin
            st_exp_t s;
            s = stq.pop_front();
            chk("st_addr", st_wb_addr, s.addr);
            chk("st_data", st_wb_data, s.data);
            chk("st_mask", 32'(st_wb_mask), 32'(s.mask));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_valid = 0; alloc_rob_tag = '0; alloc_is_store = 0;
      exec_valid = 0; exec_rob_tag = '0; exec_addr = '0; exec_data = '0;
      exec_size = '0; exec_unsigned = 0;
      commit_valid = 0; commit_rob_tag = '0;
      flush = 0; flush_rob_tag = '0;
   endtask

   task automatic alloc(input logic [4:0] t, input logic st);
      alloc_valid = 1; alloc_rob_tag = t; alloc_is_store = st;
      tick();
      alloc_valid = 0;
   endtask

   task automatic exec(input logic [4:0] t, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic u);
      exec_valid = 1; exec_rob_tag = t; exec_addr = a; exec_data = d;
      exec_size = sz; exec_unsigned = u;
      tick();
      exec_valid = 0;
   endtask

   task automatic commit(input logic [4:0] t);
      commit_valid = 1; commit_rob_tag = t;
      tick();
      commit_valid = 0;
   endtask

   task automatic exp_ld(input logic [4:0] t, input logic [1:0] k, input logic [31:0] d);
      ld_exp_t e;
      e.tag = t; e.kind = k; e.data = d;
      ldq.push_back(e);
   endtask

   task automatic exp_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      st_exp_t s;
      s.addr = a; s.data = d; s.mask = m;
      stq.push_back(s);
   endtask

   initial begin
      logic [4:0] t, prev, c;
      logic [4:0] inq[$];

      idle();
      rob_head = '0;
      reset = 1;
      tick(); tick();
      reset = 0;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_ready", 32'(alloc_ready), 1);
      chk("rst_ldv", 32'(ld_resp_valid), 0);
      chk("rst_stv", 32'(st_wb_valid), 0);

      // Full-word store forwarding into word, signed byte and unsigned byte loads
      alloc(5'd1, 1); alloc(5'd2, 0); alloc(5'd3, 0); alloc(5'd4, 0);
      chk("cnt4", 32'(count), 4);
      exec(5'd1, 32'h100, 32'hDEADBEEF, 2'b10, 0);
      exp_ld(5'd2, 2'b01, 32'hDEADBEEF); exec(5'd2, 32'h100, 32'h0, 2'b10, 0);
      exp_ld(5'd3, 2'b01, 32'hFFFFFFDE); exec(5'd3, 32'h103, 32'h0, 2'b00, 0);
      exp_ld(5'd4, 2'b01, 32'h000000DE); exec(5'd4, 32'h103, 32'h0, 2'b00, 1);
      exp_st(32'h100, 32'hDEADBEEF, 4'hF); commit(5'd1);
      commit(5'd2); commit(5'd3); commit(5'd4);
      chk("cnt_drain1", 32'(count), 0);

      // Partial coverage stalls until the store drains
      alloc(5'd5, 1); alloc(5'd6, 0);
      exec(5'd5, 32'h202, 32'h1234, 2'b01, 0);
      exp_ld(5'd6, 2'b10, 32'h0); exec(5'd6, 32'h200, 32'h0, 2'b10, 0);
      exp_st(32'h200, 32'h12340000, 4'b1100); commit(5'd5);
      exp_ld(5'd6, 2'b00, 32'h0); exec(5'd6, 32'h200, 32'h0, 2'b10, 0);
      commit(5'd6);

      // Unexecuted older store stalls; once executed at another word, MEMORY
      alloc(5'd7, 1); alloc(5'd8, 0);
      exp_ld(5'd8, 2'b10, 32'h0); exec(5'd8, 32'h300, 32'h0, 2'b10, 0);
      exec(5'd7, 32'h400, 32'hCAFEF00D, 2'b10, 0);
      exp_ld(5'd8, 2'b00, 32'h0); exec(5'd8, 32'h300, 32'h0, 2'b10, 0);
      exp_st(32'h400, 32'hCAFEF00D, 4'hF); commit(5'd7);
      commit(5'd8);
      chk("cnt_drain3", 32'(count), 0);

      // Fill to full, then alloc+commit while full: alloc refused
      for (int i = 9; i <= 16; i++) begin
         t = 5'(i);
         alloc(t, 1);
         inq.push_back(t);
      end
      chk("fill_count", 32'(count), 8);
      chk("fill_full", 32'(full), 1);
      chk("fill_ready", 32'(alloc_ready), 0);
      for (int i = 9; i <= 16; i++) begin
         t = 5'(i);
         exec(t, 32'h1000 + 32'(t) * 4, 32'h55000000 | 32'(t), 2'b10, 0);
      end
      c = inq.pop_front();
      exp_st(32'h1000 + 32'(c) * 4, 32'h55000000 | 32'(c), 4'hF);
      alloc_valid = 1; alloc_rob_tag = 5'd17; alloc_is_store = 1;
      commit_valid = 1; commit_rob_tag = c;
      tick();
      idle();
      chk("full_alloc_refused", 32'(count), 7);

      // Interleaved alloc/exec/commit wraps the pointers with steady occupancy
      prev = '0;
      for (int j = 0; j < 20; j++) begin
         t = 5'(17 + j);
         alloc_valid = 1; alloc_rob_tag = t; alloc_is_store = 1;
         if (j > 0) begin
            exec_valid = 1; exec_rob_tag = prev; exec_size = 2'b10; exec_unsigned = 0;
            exec_addr = 32'h1000 + 32'(prev) * 4; exec_data = 32'h55000000 | 32'(prev);
         end
         c = inq.pop_front();
         exp_st(32'h1000 + 32'(c) * 4, 32'h55000000 | 32'(c), 4'hF);
         commit_valid = 1; commit_rob_tag = c;
         inq.push_back(t);
         tick();
         idle();
         chk("wrap_count", 32'(count), 7);
         prev = t;
      end
      exec(prev, 32'h1000 + 32'(prev) * 4, 32'h55000000 | 32'(prev), 2'b10, 0);
      while (inq.size() > 0) begin
         c = inq.pop_front();
         exp_st(32'h1000 + 32'(c) * 4, 32'h55000000 | 32'(c), 4'hF);
         commit(c);
      end
      chk("wrap_empty", 32'(empty), 1);

      // Flush squashes tags 0 and 1; same-cycle exec of tag 0 and alloc dropped
      rob_head = 5'd14;
      alloc(5'd14, 0); alloc(5'd15, 1); alloc(5'd0, 0); alloc(5'd1, 0);
      flush = 1; flush_rob_tag = 5'd15;
      exec_valid = 1; exec_rob_tag = 5'd0; exec_addr = 32'h500; exec_size = 2'b10;
      alloc_valid = 1; alloc_rob_tag = 5'd2; alloc_is_store = 0;
      #1;
      chk("flush_ready", 32'(alloc_ready), 0);
      tick();
      idle();
      chk("flush_count", 32'(count), 2);
      alloc(5'd0, 0);
      chk("post_flush_count", 32'(count), 3);
      exec(5'd15, 32'h600, 32'h11223344, 2'b10, 0);
      exp_ld(5'd0, 2'b01, 32'h11223344); exec(5'd0, 32'h600, 32'h0, 2'b10, 0);
      exp_ld(5'd14, 2'b00, 32'h0); exec(5'd14, 32'h600, 32'h0, 2'b10, 0);
      commit(5'd14);
      exp_st(32'h600, 32'h11223344, 4'hF); commit(5'd15);
      commit(5'd0);
      chk("flush_drain", 32'(count), 0);

      // Reset on the cycle of a store commit discards the writeback
      rob_head = '0;
      alloc(5'd3, 1);
      exec(5'd3, 32'h700, 32'h1, 2'b10, 0);
      commit_valid = 1; commit_rob_tag = 5'd3; reset = 1;
      tick();
      idle();
      reset = 0;
      chk("rst_mid_stv", 32'(st_wb_valid), 0);
      chk("rst_mid_count", 32'(count), 0);
      chk("rst_mid_empty", 32'(empty), 1);

      tick(); tick();
      chk("ldq_left", 32'(ldq.size()), 0);
      chk("stq_left", 32'(stq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
